// File: rtl/fsld_seq_ctrl.sv
// First-load (FSLD) sequencer for the master FSM.
// Steers the gi FIFO to the kernel write module, then the bias write module,
// counts qualified FIFO transfers per phase, waits for each write module to
// drain, and pulses fsld_done once the phase completes.
// Optional build macro: FSLD_WATCHDOG_EN adds a stall watchdog that sets the
// sticky fsld_err and forces the sequencer back to idle.
module fsld_seq_ctrl #(
  parameter int unsigned CNT_BITS      = 16,
  parameter int unsigned FSLD_FSM_BITS = 3,
  parameter int unsigned WDOG_BITS     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               mast_current_state,
  input  logic [CNT_BITS-1:0]      ker_word_num,
  input  logic [CNT_BITS-1:0]      bias_word_num,
  input  logic                     empty_n_from_gi,
  input  logic                     read_for_gi,
  input  logic                     ker_write_busy,
  input  logic                     bias_write_busy,
  output logic [FSLD_FSM_BITS-1:0] fsld_current_state,
  output logic                     ker_write_en,
  output logic                     bias_write_enable,
  output logic                     fsld_done,
  output logic [CNT_BITS-1:0]      xfer_cnt,
  output logic                     fsld_err
);

  localparam logic [2:0] MastFsld = 3'd7;

  typedef enum logic [2:0] {
    FsIdle = 3'd0,
    FsKer  = 3'd1,
    FsBias = 3'd2,
    FsKdrn = 3'd3,
    FsDone = 3'd4,
    FsBdrn = 3'd5
  } fsld_state_e;

  fsld_state_e         state_q, state_d;
  logic [CNT_BITS-1:0] ker_num_q, ker_num_d;
  logic [CNT_BITS-1:0] bias_num_q, bias_num_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                ker_en_q, ker_en_d;
  logic                bias_en_q, bias_en_d;
  logic                done_q, done_d;

  logic                in_fsld;
  logic                xfer;
  logic                cnt_room;
  logic                wdog_expired;

  assign in_fsld = (mast_current_state == MastFsld);
  assign xfer    = read_for_gi & empty_n_from_gi;

  // Counting stops at the latched count, so the counter can never wrap.
  assign cnt_room = ((state_q == FsKer)  && (cnt_q != ker_num_q)) ||
                    ((state_q == FsBias) && (cnt_q != bias_num_q));

`ifdef FSLD_WATCHDOG_EN
  logic [WDOG_BITS-1:0] wdog_q, wdog_d;
  logic                 err_q, err_d;
  logic                 wdog_active;

  assign wdog_active  = (state_q == FsKer)  || (state_q == FsBias) ||
                        (state_q == FsKdrn) || (state_q == FsBdrn);
  assign wdog_expired = wdog_active && (wdog_q == '1);

  // Watchdog restarts on any progress (transfer or state change).
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q | wdog_expired;
    if (xfer || (state_d != state_q)) begin
      wdog_d = '0;
    end else if (wdog_active) begin
      wdog_d = wdog_q + WDOG_BITS'(1);
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign fsld_err = err_q;
`else
  logic [WDOG_BITS-1:0] unused_wdog;

  assign unused_wdog  = '0;
  assign wdog_expired = 1'b0;
  assign fsld_err     = 1'b0;
`endif

  // Next-state logic, count latching and re-arm tracking.
  always_comb begin
    state_d    = state_q;
    ker_num_d  = ker_num_q;
    bias_num_d = bias_num_q;
    armed_d    = armed_q;

    case (state_q)
      FsIdle: begin
        if (in_fsld && armed_q) begin
          ker_num_d  = ker_word_num;
          bias_num_d = bias_word_num;
          armed_d    = 1'b0;
          if (ker_word_num != '0) begin
            state_d = FsKer;
          end else if (bias_word_num != '0) begin
            state_d = FsBias;
          end else begin
            state_d = FsDone;
          end
        end
      end
      FsKer: begin
        if (xfer && cnt_room && ((cnt_q + CNT_BITS'(1)) == ker_num_q)) begin
          state_d = FsKdrn;
        end
      end
      FsKdrn: begin
        if (!ker_write_busy) begin
          state_d = (bias_num_q != '0) ? FsBias : FsDone;
        end
      end
      FsBias: begin
        if (xfer && cnt_room && ((cnt_q + CNT_BITS'(1)) == bias_num_q)) begin
          state_d = FsBdrn;
        end
      end
      FsBdrn: begin
        if (!bias_write_busy) begin
          state_d = FsDone;
        end
      end
      FsDone: begin
        state_d = FsIdle;
      end
      default: begin
        state_d = FsIdle;
      end
    endcase

    // Master abort or watchdog expiry overrides any progress.
    if ((state_q != FsIdle) && !in_fsld) begin
      state_d = FsIdle;
    end
    if (wdog_expired) begin
      state_d = FsIdle;
    end

    // A new load is accepted only after the master has left FSLD.
    if (!in_fsld) begin
      armed_d = 1'b1;
    end
  end

  // Transfer counter: clears on every phase change, counts qualified transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer && cnt_room) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Registered outputs decoded from the next state so they align with state_q.
  always_comb begin
    ker_en_d  = (state_d == FsKer);
    bias_en_d = (state_d == FsBias);
    done_d    = (state_d == FsDone);
  end

  // State, latched counts, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FsIdle;
      ker_num_q  <= '0;
      bias_num_q <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      ker_en_q   <= 1'b0;
      bias_en_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ker_num_q  <= ker_num_d;
      bias_num_q <= bias_num_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      ker_en_q   <= ker_en_d;
      bias_en_q  <= bias_en_d;
      done_q     <= done_d;
    end
  end

  assign fsld_current_state = FSLD_FSM_BITS'(state_q);
  assign ker_write_en       = ker_en_q;
  assign bias_write_enable  = bias_en_q;
  assign fsld_done          = done_q;
  assign xfer_cnt           = cnt_q;

endmodule
